// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared ISA constants for the MIPS core's custom opcode map.
//   - 6-bit opcodes, identical to the control unit's decode
//   - 4-bit mnemonic enumeration used by the program loader
//   - instruction field widths and bit positions
package mips_isa_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OP_W     = 6;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned IMM_W    = 16;
   localparam int unsigned TARGET_W = 26;
   localparam int unsigned MNEM_W   = 4;

   // Field LSB positions within the 32-bit word
   localparam int unsigned OP_LSB    = 26;
   localparam int unsigned RS_LSB    = 21;
   localparam int unsigned RT_LSB    = 16;
   localparam int unsigned RD_LSB    = 11;
   localparam int unsigned SHAMT_LSB = 6;

   // Opcodes [31:26]
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b000010;
   localparam logic [OP_W-1:0] OP_SUBI  = 6'b000011;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b000100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b000101;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b000111;
   localparam logic [OP_W-1:0] OP_LW    = 6'b001000;
   localparam logic [OP_W-1:0] OP_LB    = 6'b001001;
   localparam logic [OP_W-1:0] OP_SW    = 6'b010000;
   localparam logic [OP_W-1:0] OP_SB    = 6'b010001;
   localparam logic [OP_W-1:0] OP_MOVE  = 6'b100000;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b100011;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b100111;
   localparam logic [OP_W-1:0] OP_J     = 6'b111000;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b111001;

   typedef enum logic [MNEM_W-1:0] {
      MN_R       = 4'd0,
      MN_ADDI    = 4'd1,
      MN_SUBI    = 4'd2,
      MN_ANDI    = 4'd3,
      MN_ORI     = 4'd4,
      MN_LW      = 4'd5,
      MN_SW      = 4'd6,
      MN_LB      = 4'd7,
      MN_SB      = 4'd8,
      MN_SLTI    = 4'd9,
      MN_BEQ     = 4'd10,
      MN_BNE     = 4'd11,
      MN_J       = 4'd12,
      MN_JAL     = 4'd13,
      MN_MOVE    = 4'd14,
      MN_INVALID = 4'd15
   } mnem_e;

   // I-format word: {op, rs, rt, imm}
   function automatic logic [INSTR_W-1:0] pack_i(input logic [OP_W-1:0]  op,
                                                 input logic [REG_W-1:0] rs,
                                                 input logic [REG_W-1:0] rt,
                                                 input logic [IMM_W-1:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational encoder from mnemonic + fields to a
// 32-bit machine word.
//   i_mnem      mnemonic index (mnem_e encoding)
//   i_rs/i_rt/i_rd/i_shamt/i_funct/i_imm/i_target  instruction fields
//   o_word_c    encoded word (0 when invalid)
//   o_valid_c   1 for every mnemonic except MN_INVALID
module instr_field_packer
   import mips_isa_pkg::*;
(
   input  logic [MNEM_W-1:0]   i_mnem,
   input  logic [REG_W-1:0]    i_rs,
   input  logic [REG_W-1:0]    i_rt,
   input  logic [REG_W-1:0]    i_rd,
   input  logic [REG_W-1:0]    i_shamt,
   input  logic [FUNCT_W-1:0]  i_funct,
   input  logic [IMM_W-1:0]    i_imm,
   input  logic [TARGET_W-1:0] i_target,
   output logic [INSTR_W-1:0]  o_word_c,
   output logic                o_valid_c
);

   // Format selection; fields not used by a format are ignored
   always_comb begin
      o_word_c  = '0;
      o_valid_c = 1'b1;
      case (mnem_e'(i_mnem))
         MN_R:    o_word_c = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
         MN_ADDI: o_word_c = pack_i(OP_ADDI, i_rs, i_rt, i_imm);
         MN_SUBI: o_word_c = pack_i(OP_SUBI, i_rs, i_rt, i_imm);
         MN_ANDI: o_word_c = pack_i(OP_ANDI, i_rs, i_rt, i_imm);
         MN_ORI:  o_word_c = pack_i(OP_ORI,  i_rs, i_rt, i_imm);
         MN_LW:   o_word_c = pack_i(OP_LW,   i_rs, i_rt, i_imm);
         MN_SW:   o_word_c = pack_i(OP_SW,   i_rs, i_rt, i_imm);
         MN_LB:   o_word_c = pack_i(OP_LB,   i_rs, i_rt, i_imm);
         MN_SB:   o_word_c = pack_i(OP_SB,   i_rs, i_rt, i_imm);
         MN_SLTI: o_word_c = pack_i(OP_SLTI, i_rs, i_rt, i_imm);
         MN_BEQ:  o_word_c = pack_i(OP_BEQ,  i_rs, i_rt, i_imm);
         MN_BNE:  o_word_c = pack_i(OP_BNE,  i_rs, i_rt, i_imm);
         MN_J:    o_word_c = {OP_J,   i_target};
         MN_JAL:  o_word_c = {OP_JAL, i_target};
         MN_MOVE: o_word_c = pack_i(OP_MOVE, i_rs, i_rt, 16'h0000);
         default: o_valid_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes one instruction per handshake and writes it
// to instruction memory at consecutive addresses starting from 0.
//   clk, reset(sync, active-high), clear(sync restart at address 0)
//   in_valid/in_ready      instruction handshake
//   mnem, rs, rt, rd, shamt, funct, imm, target   instruction fields
//   imem_we/imem_addr/imem_wdata   registered one-cycle memory write
//   err_invalid            pulse when an invalid mnemonic is dropped
//   full, count            load progress
module instr_encoder_loader
   import mips_isa_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MNEM_W-1:0]   mnem,
   input  logic [REG_W-1:0]    rs,
   input  logic [REG_W-1:0]    rt,
   input  logic [REG_W-1:0]    rd,
   input  logic [REG_W-1:0]    shamt,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic [IMM_W-1:0]    imm,
   input  logic [TARGET_W-1:0] target,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [INSTR_W-1:0]  imem_wdata,
   output logic                err_invalid,
   output logic                full,
   output logic [ADDR_W:0]     count
);

   localparam int unsigned      CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic {S_LOAD = 1'b0, S_FULL = 1'b1} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic                  r_in_ready;
   logic                  r_imem_we;
   logic [ADDR_W-1:0]     r_imem_addr;
   logic [INSTR_W-1:0]    r_imem_wdata;
   logic                  r_err_invalid;
   logic                  r_full;
   logic [CNT_W-1:0]      r_count;

   logic [INSTR_W-1:0]    w_word;
   logic                  w_word_valid;
   logic                  w_accept;
   logic [CNT_W-1:0]      w_count_inc;

   instr_field_packer u_packer (
      .i_mnem    (mnem),
      .i_rs      (rs),
      .i_rt      (rt),
      .i_rd      (rd),
      .i_shamt   (shamt),
      .i_funct   (funct),
      .i_imm     (imm),
      .i_target  (target),
      .o_word_c  (w_word),
      .o_valid_c (w_word_valid)
   );

   // clear overrides any simultaneous handshake
   assign w_accept    = in_valid && (r_state == S_LOAD) && !clear;
   assign w_count_inc = r_count + CNT_W'(1);

   // Next-state: FULL after the DEPTH-th valid word, left only by clear/reset
   always_comb begin
      w_state_next = r_state;
      if (clear) begin
         w_state_next = S_LOAD;
      end else begin
         case (r_state)
            S_LOAD: if (w_accept && w_word_valid && (w_count_inc == DEPTH_C))
                       w_state_next = S_FULL;
            S_FULL: w_state_next = S_FULL;
            default: w_state_next = S_LOAD;
         endcase
      end
   end

   // State, counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_LOAD;
         r_in_ready    <= 1'b1;
         r_imem_we     <= 1'b0;
         r_imem_addr   <= '0;
         r_imem_wdata  <= '0;
         r_err_invalid <= 1'b0;
         r_full        <= 1'b0;
         r_count       <= '0;
      end else begin
         r_state       <= w_state_next;
         r_in_ready    <= (w_state_next == S_LOAD);
         r_full        <= (w_state_next == S_FULL);
         r_imem_we     <= 1'b0;
         r_err_invalid <= 1'b0;
         if (clear) begin
            r_count <= '0;
         end else if (w_accept) begin
            if (w_word_valid) begin
               r_imem_we    <= 1'b1;
               r_imem_addr  <= r_count[ADDR_W-1:0];
               r_imem_wdata <= w_word;
               r_count      <= w_count_inc;
            end else begin
               r_err_invalid <= 1'b1;
            end
         end
      end
   end

   assign in_ready    = r_in_ready;
   assign imem_we     = r_imem_we;
   assign imem_addr   = r_imem_addr;
   assign imem_wdata  = r_imem_wdata;
   assign err_invalid = r_err_invalid;
   assign full        = r_full;
   assign count       = r_count;

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Streaming instruction encoder and program loader for the 32-bit MIPS core. It encodes one instruction per handshake (mnemonic index plus fields) into a 32-bit machine word. The word uses the core's custom opcode map, exactly as the control unit decodes it. Each encoded word is written into instruction memory at consecutive addresses starting from 0, so a testbench or boot source can build programs without hand-assembling hex.

## Interface
- `ADDR_W`, 8: instruction memory word-address width.
- `DEPTH`, 256: number of words loadable before full; must be ≤ 2^ADDR_W.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; returns the block to its reset state.
- `clear`  in  1  synchronous restart of loading at address 0 (state/counters only).
- `in_valid`  in  1  instruction fields presented.
- `in_ready`  out  1  block can accept this cycle.
- `mnem`  in  4  mnemonic index: 0 R, 1 addi, 2 subi, 3 andi, 4 ori, 5 lw, 6 sw, 7 lb, 8 sb, 9 slti, 10 beq, 11 bne, 12 j, 13 jal, 14 move, 15 invalid.
- `rs`, `rt`, `rd`, `shamt`  in  5 each  register and shift fields.
- `funct`  in  6  R-type function field.
- `imm`  in  16  I-type immediate/offset, used verbatim.
- `target`  in  26  J-type target, used verbatim.
- `imem_we`  out  1  one-cycle write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  32  encoded word.
- `err_invalid`  out  1  one-cycle pulse: invalid mnemonic accepted and dropped.
- `full`  out  1  DEPTH words written.
- `count`  out  ADDR_W+1  words written since reset/clear.

## Operation
- Opcodes [31:26]: R 000000, addi 000010, subi 000011, andi 000100, ori 000101, lw 001000, lb 001001, sw 010000, sb 010001, slti 000111, beq 100011, bne 100111, move 100000, j 111000, jal 111001.
- R format: `{op, rs, rt, rd, shamt, funct}`.
- I format (addi..bne): `{op, rs, rt, imm}`.
- move: `{100000, rs, rt, 16'h0000}`; other fields are ignored.
- J format (j, jal): `{op, target}`.
- The block performs no sign extension, offset arithmetic or range checking. Unused fields for a format are ignored.
- FSM has two states:
  - LOAD: in_ready=1.
  - FULL: in_ready=0. Left only by clear or reset.
- Accept occurs when in_valid && in_ready.
- A valid mnemonic registers the word, with imem_addr = count. count increments by 1. The word is written on the next cycle.
- mnem=15 is accepted: no write occurs, count is unchanged, and err_invalid pulses on the next cycle.
- When count reaches DEPTH, the FSM enters FULL and full=1.
- Reset values: state LOAD, count 0, full 0, imem_we 0, err_invalid 0, imem_addr 0, imem_wdata 0.

## Timing
- Latency: an accept in cycle N produces imem_we=1 in cycle N+1 only, with that cycle's address and data.
- Throughput: one instruction per cycle, sustained.
- The DEPTH-th accept in cycle N gives full=1 and in_ready=0 from N+1. No accept is possible in N+1.
- clear has priority over accept:
  - count goes to 0 and the FSM to LOAD.
  - imem_we is 0 in the next cycle and the simultaneous input is dropped.
  - A write already strobing in the clear cycle completes.
- reset behaves as clear and also zeroes imem_addr and imem_wdata. Asserting it mid-stream loses any pending word.
- in_valid while in_ready=0: ignored, with no side effects.
- in_ready is a registered function of state only; it does not depend on in_valid.

## Structure
- Shared package `mips_isa_pkg`:
  - 6-bit opcode localparams, identical to the control unit's decode.
  - 4-bit mnemonic enumeration.
  - Field position constants.
- Sub-module `instr_field_packer`: purely combinational; takes mnem and fields, outputs word + valid flag.
- The top level holds the FSM, counter and output registers.

## Test plan
- Reset, then addi rs=1 rt=2 imm=0x0005 → cycle+1: imem_we=1, addr 0, wdata 0x08220005, count 1.
- Back-to-back R (rs=1,rt=2,rd=3,funct=0x20), jal target=0x0000010, move rs=4 rt=5:
  - writes 0x00221820 @0, 0xE4000010 @1, 0x80850000 @2 on consecutive cycles.
- mnem=15 between two valid words → err_invalid pulse, no write, addresses 0 and 1 contiguous.
- DEPTH=4: hold in_valid high for 6 cycles:
  - 4 writes at addr 0..3.
  - full=1 and in_ready=0 from the cycle after the 4th accept.
  - inputs 5–6 are dropped.
- While FULL, pulse clear with in_valid=1 → no write next cycle, count 0; the next accept writes addr 0.
- reset asserted the cycle after an accept of beq rs=3 rt=4 imm=0xFFFE:
  - the write strobe in the reset cycle completes (0x8C64FFFE @0).
  - afterwards all outputs are 0, and the next word goes to addr 0.
